// File: rtl/tristate_bus_reader_pkg.sv
// Shared definitions for the tri-state bus read master.
package tristate_bus_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Chip-select level that makes a slave float the bus; replicate for a full vector.
  localparam logic CsDeselected = 1'b1;

  // Settle counter width: holds SettleCycles-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/tristate_bus_reader_bus_cs_decoder.sv
// Active-low one-hot chip-select decoder; all ones when disabled or out of range.
module bus_cs_decoder #(
  parameter int unsigned NrOfSlaves = 4,
  parameter int unsigned SelWidth   = 2
) (
  input  logic [SelWidth-1:0]   sel,
  input  logic                  en,
  output logic [NrOfSlaves-1:0] cs_n
);

  // Drive the selected line low; indices >= NrOfSlaves match no line.
  always_comb begin
    cs_n = '1;
    for (int unsigned i = 0; i < NrOfSlaves; i++) begin
      if (en && (sel == SelWidth'(i))) begin
        cs_n[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_reader.sv
// Read-side master for the shared tri-state register bus: selects one slave,
// waits a settle window, samples the bus and returns the word on a valid/ready channel.
module tristate_bus_reader
  import tristate_bus_reader_pkg::*;
#(
  parameter int unsigned NrOfBits     = 32,
  parameter int unsigned NrOfSlaves   = 4,
  parameter int unsigned SelWidth     = 2,
  parameter int unsigned SettleCycles = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SelWidth-1:0]   req_sel,
  output logic [NrOfSlaves-1:0] cs,
  input  logic [NrOfBits-1:0]   bus_in,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [NrOfBits-1:0]   rsp_data,
  output logic [SelWidth-1:0]   rsp_sel,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned CntWidth = cnt_width(SettleCycles);
  localparam logic [NrOfSlaves-1:0] CsNone = {NrOfSlaves{CsDeselected}};

  state_t                state;
  logic [CntWidth-1:0]   cnt;
  logic [NrOfSlaves-1:0] dec_cs;
  logic                  sel_hit;

  bus_cs_decoder #(
    .NrOfSlaves (NrOfSlaves),
    .SelWidth   (SelWidth)
  ) u_dec (
    .sel  (req_sel),
    .en   (req_valid),
    .cs_n (dec_cs)
  );

  // A request index is in range exactly when the decoder pulls some line low.
  assign sel_hit   = ~&dec_cs;
  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;

  // Transaction FSM with registered chip-selects and response outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      cs        <= CsNone;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_sel   <= '0;
      rsp_err   <= 1'b0;
    end else if (Tick) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rsp_sel <= req_sel;
            if (sel_hit) begin
              state <= SETTLE;
              cs    <= dec_cs;
              cnt   <= CntWidth'(SettleCycles - 1);
            end else begin
              state     <= RESP;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_valid <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            rsp_data  <= bus_in;
            cs        <= CsNone;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - CntWidth'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cs    <= CsNone;
        end
      endcase
    end
  end

endmodule
